exec_sequencer: RTL

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer_pkg.sv | 27 ++
 rtl/exec_sequencer_pc_next_calc.sv | 29 ++
 rtl/exec_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execution sequencer: FSM states, opcodes, defaults.
package exec_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      COMMIT = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [5:0]  OP_RTYPE = 6'h00;
   localparam logic [5:0]  OP_BEQ   = 6'h04;
   localparam logic [5:0]  OP_BNE   = 6'h05;
   localparam logic [5:0]  OP_LW    = 6'h23;
   localparam logic [5:0]  OP_SW    = 6'h2B;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

   // Loads and stores are the only instructions that visit the data memory.
   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/exec_sequencer_pc_next_calc.sv
// Combinational next-pc: sequential pc+4, or pc+4+offset for a taken beq/bne.
module pc_next_calc
   import exec_sequencer_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   input  logic        i_zero,
   output logic [31:0] o_next_pc
);

   logic [5:0]         w_opcode;
   logic               w_taken;
   logic signed [31:0] w_offset;
   logic [31:0]        w_seq_pc;
   logic               w_unused;

   assign w_opcode  = i_instr[31:26];
   // Word offset: sign-extended immediate scaled by 4.
   assign w_offset  = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
   assign w_taken   = ((w_opcode == OP_BEQ) &&  i_zero) ||
                      ((w_opcode == OP_BNE) && !i_zero);
   // Addition wraps modulo 2^32 by construction.
   assign w_seq_pc  = i_pc + 32'd4;
   assign o_next_pc = w_taken ? (w_seq_pc + $unsigned(w_offset)) : w_seq_pc;

   // Register-field bits play no part in control flow.
   assign w_unused  = ^i_instr[25:16];

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode/execute, optional memory
// access, then a single-cycle commit pulse to the external datapath.
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] alu_instr,
   output logic [31:0] alu_read_data,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_store_data,
   input  logic        alu_zero,
   output logic        alu_step,
   output logic [31:0] pc,
   output logic        busy,
   output logic        halted,
   output logic [31:0] instr_count
);

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, r_instr_count, r_alu_instr, r_alu_read_data;
   logic [31:0] r_dmem_addr, r_dmem_wdata;
   logic        r_dmem_we;
   logic        w_imem_req, w_dmem_req, w_alu_step, w_busy, w_halted;
   logic [5:0]  w_opcode;
   logic        w_is_halt_word;
   logic [31:0] w_pc_next;

   assign w_opcode       = r_alu_instr[31:26];
   assign w_is_halt_word = (imem_rdata == HALT_WORD);

   // alu_zero only matters while committing, since pc is only written then.
   pc_next_calc u_pc_next (
      .i_pc      (r_pc),
      .i_instr   (r_alu_instr),
      .i_zero    (alu_zero),
      .o_next_pc (w_pc_next)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode and state-derived outputs; acks only count while the
   // matching request is raised, which is implied by the state they are used in.
   always_comb begin
      w_state_nxt = r_state;
      w_imem_req  = 1'b0;
      w_dmem_req  = 1'b0;
      w_alu_step  = 1'b0;
      w_busy      = 1'b0;
      w_halted    = 1'b0;
      case (r_state)
         IDLE: begin
            if (run) w_state_nxt = FETCH;
         end
         FETCH: begin
            w_imem_req = 1'b1;
            w_busy     = 1'b1;
            if (imem_ack) w_state_nxt = w_is_halt_word ? HALT : EXEC;
         end
         EXEC: begin
            w_busy      = 1'b1;
            w_state_nxt = is_mem_op(w_opcode) ? MEM : COMMIT;
         end
         MEM: begin
            w_dmem_req = 1'b1;
            w_busy     = 1'b1;
            if (dmem_ack) w_state_nxt = COMMIT;
         end
         COMMIT: begin
            w_alu_step  = 1'b1;
            w_busy      = 1'b1;
            w_state_nxt = FETCH;
         end
         HALT: begin
            w_halted = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Architectural registers: latched instruction, memory operands, pc, count
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc            <= RESET_PC;
         r_instr_count   <= 32'd0;
         r_alu_instr     <= 32'd0;
         r_alu_read_data <= 32'd0;
         r_dmem_addr     <= 32'd0;
         r_dmem_wdata    <= 32'd0;
         r_dmem_we       <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (imem_ack && !w_is_halt_word) r_alu_instr <= imem_rdata;
            end
            EXEC: begin
               if (is_mem_op(w_opcode)) begin
                  r_dmem_addr  <= alu_result;
                  r_dmem_wdata <= alu_store_data;
                  r_dmem_we    <= (w_opcode == OP_SW);
               end
            end
            MEM: begin
               if (dmem_ack && (w_opcode == OP_LW)) r_alu_read_data <= dmem_rdata;
            end
            COMMIT: begin
               r_pc <= w_pc_next;
               if (r_instr_count != 32'hFFFF_FFFF) r_instr_count <= r_instr_count + 32'd1;
            end
            default: ;
         endcase
      end
   end

   assign imem_req      = w_imem_req;
   assign imem_addr     = r_pc;
   assign dmem_req      = w_dmem_req;
   assign dmem_we       = r_dmem_we;
   assign dmem_addr     = r_dmem_addr;
   assign dmem_wdata    = r_dmem_wdata;
   assign alu_instr     = r_alu_instr;
   assign alu_read_data = r_alu_read_data;
   assign alu_step      = w_alu_step;
   assign pc            = r_pc;
   assign busy          = w_busy;
   assign halted        = w_halted;
   assign instr_count   = r_instr_count;

endmodule
